// File: rtl/ysyx_store_queue.sv
// ysyx_store_queue: committed-store buffer between the ROU commit port and the
// data-memory write channel. Stores are formatted into word-aligned requests
// with byte strobes and drained in commit order, one outstanding write at a time.
// Loads probe the queue for store-to-load forwarding or a stall.
// Optional feature macro: YSYX_SQ_FWD_EN (defined: forward full hits;
// undefined: any overlap stalls, no forwarding).

`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_store_queue #(
    parameter int unsigned XLEN    = `YSYX_XLEN,
    parameter int unsigned SQ_SIZE = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rou_valid,
    input  logic            rou_store,
    input  logic [4:0]      rou_alu,
    input  logic [XLEN-1:0] rou_waddr,
    input  logic [XLEN-1:0] rou_wdata,
    input  logic [XLEN-1:0] rou_pc,
    output logic            rou_sq_ready,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_resp_valid,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  logic [1:0]      ld_size,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_data,
    output logic            fwd_stall,
    output logic            sq_empty
);

    localparam int unsigned PTR_W = $clog2(SQ_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e            state_q;
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [XLEN-3:0]   waddr_q [SQ_SIZE];
    logic [XLEN-1:0]   data_q  [SQ_SIZE];
    logic [3:0]        strb_q  [SQ_SIZE];

    logic              push, pop;
    logic [3:0]        st_strb;
    logic [XLEN-1:0]   st_data;

    logic [3:0]        lm;
    logic              sel_found;
    logic [3:0]        sel_strb;
    logic [XLEN-1:0]   sel_data;
    logic [PTR_W-1:0]  idx;

    // Debug-only and reserved op bits are not needed for the write path.
    logic unused_ok;
    assign unused_ok = ^{rou_pc, rou_alu[4:2]};

    // Byte-lane mask for a size/offset; halfword ignores the odd-byte bit.
    function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   byte_mask = 4'b0001 << off;
            2'b01:   byte_mask = 4'b0011 << {off[1], 1'b0};
            default: byte_mask = 4'b1111;
        endcase
    endfunction

    assign rou_sq_ready = (count_q != CNT_W'(SQ_SIZE));
    assign sq_empty     = (count_q == '0);
    assign push         = rou_valid & rou_store & rou_sq_ready;
    assign pop          = (state_q == StWait) & mem_resp_valid;

    // Format an incoming store into lane-positioned data and strobes.
    always_comb begin
        st_strb = byte_mask(rou_alu[1:0], rou_waddr[1:0]);
        case (rou_alu[1:0])
            2'b00:   st_data = {4{rou_wdata[7:0]}};
            2'b01:   st_data = {2{rou_wdata[15:0]}};
            default: st_data = rou_wdata;
        endcase
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry storage; written at the tail on accept, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            waddr_q[tail_q] <= rou_waddr[XLEN-1:2];
            data_q[tail_q]  <= st_data;
            strb_q[tail_q]  <= st_strb;
        end
    end

    // Pointers, count and the drain FSM with registered request valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            mem_req_valid <= 1'b0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            count_q <= count_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_q       <= StReq;
                        mem_req_valid <= 1'b1;
                    end
                end
                StReq: begin
                    if (mem_req_ready) begin
                        state_q       <= StWait;
                        mem_req_valid <= 1'b0;
                    end
                end
                StWait: begin
                    if (mem_resp_valid) begin
                        if (count_d != '0) begin
                            state_q       <= StReq;
                            mem_req_valid <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    mem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    // Head entry is presented only while the request is valid; head is frozen then.
    assign mem_addr  = mem_req_valid ? {waddr_q[head_q], 2'b00} : '0;
    assign mem_wdata = mem_req_valid ? data_q[head_q] : '0;
    assign mem_wstrb = mem_req_valid ? strb_q[head_q] : '0;

    // Scan oldest to youngest so the last overlapping entry (the youngest) wins.
    always_comb begin
        lm        = byte_mask(ld_size, ld_addr[1:0]);
        sel_found = 1'b0;
        sel_strb  = '0;
        sel_data  = '0;
        idx       = '0;
        for (int i = 0; i < SQ_SIZE; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (waddr_q[idx] == ld_addr[XLEN-1:2]) &&
                ((strb_q[idx] & lm) != 4'b0)) begin
                sel_found = 1'b1;
                sel_strb  = strb_q[idx];
                sel_data  = data_q[idx];
            end
        end
    end

`ifdef YSYX_SQ_FWD_EN
    assign fwd_hit   = ld_valid & sel_found & ((lm & ~sel_strb) == 4'b0);
    assign fwd_stall = ld_valid & sel_found & ((lm & ~sel_strb) != 4'b0);
    assign fwd_data  = fwd_hit ? sel_data : '0;
`else
    logic unused_sel;
    assign unused_sel = ^{sel_strb, sel_data};
    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign fwd_stall  = ld_valid & sel_found;
`endif

endmodule

// File: tb/tb_ysyx_store_queue.sv
// Self-checking bench for ysyx_store_queue: directed scenarios with literal
// expectations, then randomized traffic against a queue-based reference model.
module tb_ysyx_store_queue;

    localparam int SQ = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        rou_valid, rou_store;
    logic [4:0]  rou_alu;
    logic [31:0] rou_waddr, rou_wdata, rou_pc;
    logic        rou_sq_ready;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        fwd_hit, fwd_stall, sq_empty;
    logic [31:0] fwd_data;

    always #5 clock = ~clock;

    ysyx_store_queue #(.XLEN(32), .SQ_SIZE(SQ)) u_dut (
        .clock(clock), .reset(reset),
        .rou_valid(rou_valid), .rou_store(rou_store), .rou_alu(rou_alu),
        .rou_waddr(rou_waddr), .rou_wdata(rou_wdata), .rou_pc(rou_pc),
        .rou_sq_ready(rou_sq_ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .sq_empty(sq_empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    int   vectors = 0;
    int   miscompares = 0;
    ent_t q[$];          // pending stores, oldest first
    bit   req_up;        // a write request should be on the bus
    bit   in_flight;     // request accepted, waiting for completion

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t fmt(input logic [31:0] a, input logic [31:0] d,
                                 input logic [1:0] sz);
        ent_t e;
        int   off;
        off    = int'(a % 4);
        e.addr = a - (a % 4);
        if (sz == 2'd0) begin
            e.strb = 4'(1 << off);
            e.data = (d % 256) * 32'h0101_0101;
        end else if (sz == 2'd1) begin
            e.strb = 4'(3 << ((off / 2) * 2));
            e.data = (d % 65536) * 32'h0001_0001;
        end else begin
            e.strb = 4'hF;
            e.data = d;
        end
        return e;
    endfunction

    // Registered-side outputs, sampled at the falling edge.
    task automatic check_regs();
        check("rou_sq_ready", 32'(rou_sq_ready), 32'(q.size() != SQ));
        check("sq_empty", 32'(sq_empty), 32'(q.size() == 0));
        check("mem_req_valid", 32'(mem_req_valid), 32'(req_up));
        if (req_up && q.size() != 0) begin
            check("mem_addr", mem_addr, q[0].addr);
            check("mem_wdata", mem_wdata, q[0].data);
            check("mem_wstrb", 32'(mem_wstrb), 32'(q[0].strb));
        end
    endtask

    // Lookup outputs for the currently applied load.
    task automatic check_fwd();
        logic        eh, es;
        logic [31:0] ed;
        ent_t        lm;
        eh = 1'b0; es = 1'b0; ed = '0;
        if (ld_valid) begin
            lm = fmt(ld_addr, 32'h0, ld_size);
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].addr == lm.addr && (q[i].strb & lm.strb) != 4'h0) begin
`ifdef YSYX_SQ_FWD_EN
                    if ((lm.strb & ~q[i].strb) == 4'h0) begin
                        eh = 1'b1;
                        ed = q[i].data;
                    end else begin
                        es = 1'b1;
                    end
`else
                    es = 1'b1;
`endif
                    break;
                end
            end
        end
        check("fwd_hit", 32'(fwd_hit), 32'(eh));
        check("fwd_stall", 32'(fwd_stall), 32'(es));
        if (eh) check("fwd_data", fwd_data, ed);
    endtask

    // Advance the reference model by one clock using the applied inputs.
    task automatic model_update();
        int  size0;
        bit  accept, resp;
        size0  = q.size();
        accept = rou_valid && rou_store && (size0 != SQ);
        resp   = in_flight && mem_resp_valid;
        if (reset) begin
            q.delete();
            req_up    = 0;
            in_flight = 0;
        end else begin
            if (accept) q.push_back(fmt(rou_waddr, rou_wdata, rou_alu[1:0]));
            if (req_up) begin
                if (mem_req_ready) begin
                    req_up    = 0;
                    in_flight = 1;
                end
            end else if (in_flight) begin
                if (resp) begin
                    void'(q.pop_front());
                    in_flight = 0;
                    req_up    = (q.size() != 0);
                end
            end else if (size0 != 0) begin
                req_up = 1;
            end
        end
    endtask

    // One clock: lookup check, edge, model step, registered check at falling edge.
    task automatic tick();
        #1;
        check_fwd();
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_regs();
    endtask

    task automatic idle_inputs();
        rou_valid = 0; rou_store = 0; rou_alu = 5'd0;
        rou_waddr = '0; rou_wdata = '0; rou_pc = '0;
        mem_req_ready = 0; mem_resp_valid = 0;
        ld_valid = 0; ld_addr = '0; ld_size = 2'd0;
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        rou_valid = 1; rou_store = 1; rou_alu = {3'b000, sz};
        rou_waddr = a; rou_wdata = d; rou_pc = 32'h8000_1000;
    endtask

    // Single store through an empty queue with literal expectations on the request.
    task automatic store_and_drain(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] sz, input logic [31:0] ea,
                                   input logic [31:0] ed, input logic [3:0] es);
        put_store(a, d, sz);
        mem_req_ready = 1;
        tick();
        rou_valid = 0;
        check("lit_valid_1cyc", 32'(mem_req_valid), 32'h0);
        tick();
        check("lit_valid_2cyc", 32'(mem_req_valid), 32'h1);
        check("lit_addr", mem_addr, ea);
        check("lit_wdata", mem_wdata, ed);
        check("lit_wstrb", 32'(mem_wstrb), 32'(es));
        tick();
        mem_req_ready = 0;
        mem_resp_valid = 1;
        tick();
        mem_resp_valid = 0;
        check("lit_empty_after_pop", 32'(sq_empty), 32'h1);
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        req_up = 0;
        in_flight = 0;
        @(negedge clock);
        tick();
        tick();
        check("lit_reset_ready", 32'(rou_sq_ready), 32'h1);
        check("lit_reset_empty", 32'(sq_empty), 32'h1);
        check("lit_reset_valid", 32'(mem_req_valid), 32'h0);
        check("lit_reset_addr", mem_addr, 32'h0);
        reset = 0;
        tick();

        store_and_drain(32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 32'h8000_0004, 32'hDEAD_BEEF, 4'hF);
        store_and_drain(32'h8000_0003, 32'h1234_5678, 2'd0, 32'h8000_0000, 32'h7878_7878, 4'h8);
        store_and_drain(32'h8000_0006, 32'h0000_ABCD, 2'd1, 32'h8000_0004, 32'hABCD_ABCD, 4'hC);

        // Fill the queue with memory stalled.
        for (int i = 0; i < 4; i++) begin
            put_store(32'h2000_0000 + 32'(4 * i), 32'h1111_0000 + 32'(i), 2'd2);
            tick();
        end
        check("lit_full_ready", 32'(rou_sq_ready), 32'h0);
        put_store(32'h2000_0040, 32'h5555_5555, 2'd2);
        tick();
        tick();
        check("lit_full_hold", 32'(rou_sq_ready), 32'h0);
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        mem_resp_valid = 1;  // pop and held store in the same cycle
        tick();
        mem_resp_valid = 0;
        check("lit_pop_ready", 32'(rou_sq_ready), 32'h1);
        tick();
        rou_valid = 0;
        check("lit_refill_ready", 32'(rou_sq_ready), 32'h0);
        mem_req_ready = 1;
        mem_resp_valid = 1;
        for (int i = 0; i < 12; i++) tick();
        mem_req_ready = 0;
        mem_resp_valid = 0;
        check("lit_drained", 32'(sq_empty), 32'h1);

        // Forwarding lookups with the memory side stalled.
        put_store(32'h0000_0100, 32'hAABB_CCDD, 2'd2);
        tick();
        put_store(32'h0000_0104, 32'h0000_0055, 2'd0);
        tick();
        rou_valid = 0;
        ld_valid = 1; ld_addr = 32'h100; ld_size = 2'd2;
        #1;
`ifdef YSYX_SQ_FWD_EN
        check("lit_lw100_hit", 32'(fwd_hit), 32'h1);
        check("lit_lw100_data", fwd_data, 32'hAABB_CCDD);
        tick();
        ld_addr = 32'h104; ld_size = 2'd2;
        #1;
        check("lit_lw104_stall", 32'(fwd_stall), 32'h1);
        tick();
        ld_addr = 32'h104; ld_size = 2'd0;
        #1;
        check("lit_lb104_hit", 32'(fwd_hit), 32'h1);
        check("lit_lb104_data", fwd_data, 32'h5555_5555);
`else
        check("lit_lw100_stall", 32'(fwd_stall), 32'h1);
        check("lit_lw100_nohit", 32'(fwd_hit), 32'h0);
`endif
        tick();
        ld_addr = 32'h108; ld_size = 2'd2;
        #1;
        check("lit_lw108_hit", 32'(fwd_hit), 32'h0);
        check("lit_lw108_stall", 32'(fwd_stall), 32'h0);
        tick();
        ld_valid = 0;

        // Reset while a write is outstanding; a late response must be dropped.
        mem_req_ready = 1;
        tick();
        tick();
        mem_req_ready = 0;
        reset = 1;
        tick();
        reset = 0;
        mem_resp_valid = 1;
        check("lit_rst_wait_empty", 32'(sq_empty), 32'h1);
        tick();
        mem_resp_valid = 0;
        check("lit_late_resp_valid", 32'(mem_req_valid), 32'h0);
        check("lit_late_resp_empty", 32'(sq_empty), 32'h1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 299) == 0);
            rou_valid      = $urandom_range(0, 1) == 1;
            rou_store      = $urandom_range(0, 3) != 0;
            rou_alu        = {3'($urandom), 2'($urandom_range(0, 2))};
            rou_waddr      = 32'h100 + 32'($urandom_range(0, 15));
            rou_wdata      = $urandom;
            rou_pc         = $urandom;
            mem_req_ready  = $urandom_range(0, 1) == 1;
            mem_resp_valid = $urandom_range(0, 2) == 0;
            ld_valid       = $urandom_range(0, 1) == 1;
            ld_addr        = 32'h100 + 32'($urandom_range(0, 15));
            ld_size        = 2'($urandom_range(0, 2));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
